// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO for the JTAG command engine.
// Start bit is found on a synchronized falling edge; bits are sampled mid-cell.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 1000000,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  RXD,
  input  logic                  RX_RD_REQ,
  output logic                  RX_EMPTY,
  output logic [7:0]            RX_DATA,
  output logic [DEPTH_LOG2:0]   RX_USEDW,
  output logic                  OVERRUN,
  output logic                  FRAME_ERR,
  input  logic                  CLR_ERR
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned TMR_W = $clog2(DIV);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(DIV - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx_fifo: CLK_HZ/BAUD must be at least 4");
  end

  logic             r_sync1, r_sync2, r_prev;
  logic [1:0]       r_state, w_state;
  logic [TMR_W-1:0] r_tmr, w_tmr;
  logic [2:0]       r_idx, w_idx;
  logic [7:0]       r_shift, w_shift;
  logic             w_push, w_ferr, w_fall, w_tmr_exp;
  logic             r_frame_err, r_overrun;

  logic [7:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
  logic              w_empty, w_full, w_pop, w_wr;

  // Two-flop synchronizer plus previous sample for edge detection
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall    = r_prev & ~r_sync2;
  assign w_tmr_exp = (r_tmr == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tmr       <= w_tmr;
      r_idx       <= w_idx;
      r_shift     <= w_shift;
      r_frame_err <= w_ferr;
    end
  end

  // Receiver next-state: timer expiry marks the middle of each bit cell
  always_comb begin
    w_state = r_state;
    w_tmr   = w_tmr_exp ? r_tmr : r_tmr - TMR_W'(1);
    w_idx   = r_idx;
    w_shift = r_shift;
    w_push  = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state = S_START;
          w_tmr   = TMR_HALF;
        end
      end
      S_START: begin
        if (w_tmr_exp) begin
          if (r_sync2) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_DATA;
            w_tmr   = TMR_FULL;
            w_idx   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (w_tmr_exp) begin
          w_shift = {r_sync2, r_shift[7:1]};
          w_tmr   = TMR_FULL;
          w_idx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tmr_exp) begin
          w_push  = r_sync2;
          w_ferr  = ~r_sync2;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_pop   = RX_RD_REQ & ~w_empty;
  // When full, a simultaneous pop frees the slot being written
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= r_shift;
        r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2+1)'(1);
      end
    end
  end

  // Sticky overrun; a new drop beats a simultaneous clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (CLR_ERR) begin
      r_overrun <= 1'b0;
    end
  end

  assign RX_EMPTY  = w_empty;
  assign RX_DATA   = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign RX_USEDW  = r_wr_ptr - r_rd_ptr;
  assign OVERRUN   = r_overrun;
  assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: drives 8N1 frames and checks the FIFO side.
module tb_uart_rx_fifo;

  localparam int unsigned DIV   = 12;
  localparam int unsigned DEPTH = 16;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       RXD = 1'b1;
  logic       RX_RD_REQ = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       RX_EMPTY;
  logic [7:0] RX_DATA;
  logic [4:0] RX_USEDW;
  logic       OVERRUN;
  logic       FRAME_ERR;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  uart_rx_fifo #(.CLK_HZ(12000000), .BAUD(1000000), .DEPTH_LOG2(4)) dut (
    .CLK(CLK), .nRST(nRST), .RXD(RXD), .RX_RD_REQ(RX_RD_REQ),
    .RX_EMPTY(RX_EMPTY), .RX_DATA(RX_DATA), .RX_USEDW(RX_USEDW),
    .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one frame; the scoreboard is updated once the frame is complete
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    RXD = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) tick();
    end
    RXD = stop_ok;
    repeat (DIV) tick();
    RXD = 1'b1;
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic do_pop(output logic emp, output logic [7:0] data);
    emp  = RX_EMPTY;
    data = RX_DATA;
    RX_RD_REQ = 1'b1;
    tick();
    RX_RD_REQ = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    RXD  = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({RX_EMPTY, RX_USEDW, RX_DATA, OVERRUN, FRAME_ERR} !== {1'b1, 5'd0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: empty=%b usedw=%0d data=%h ovr=%b ferr=%b, required 1/0/00/0/0",
               RX_EMPTY, RX_USEDW, RX_DATA, OVERRUN, FRAME_ERR);
    end
    nRST = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    logic e0, e1, emp;
    logic [7:0] d1, d, exp_b;
    logic [4:0] u1;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (116) tick();
        e0 = RX_EMPTY;
        RX_RD_REQ = 1'b1;
        tick();
        RX_RD_REQ = 1'b0;
        e1 = RX_EMPTY; d1 = RX_DATA; u1 = RX_USEDW;
      end
    join
    n_cmp++;
    if (e0 !== 1'b1) begin n_err++; $display("FAIL single_pre_push: empty=%b, required 1", e0); end
    n_cmp++;
    if ({e1, d1, u1} !== {1'b0, 8'hA5, 5'd1}) begin
      n_err++;
      $display("FAIL single_push: empty=%b data=%h usedw=%0d, required 0/a5/1", e1, d1, u1);
    end
    exp_b = exp_q.pop_front();
    do_pop(emp, d);
    n_cmp++;
    if ({emp, d} !== {1'b0, exp_b}) begin
      n_err++; $display("FAIL single_pop: empty=%b data=%h, required 0/%h", emp, d, exp_b);
    end
    n_cmp++;
    if ({RX_EMPTY, RX_USEDW} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL single_after_pop: empty=%b usedw=%0d, required 1/0", RX_EMPTY, RX_USEDW);
    end
    RX_RD_REQ = 1'b1;
    repeat (3) tick();
    RX_RD_REQ = 1'b0;
    n_cmp++;
    if ({RX_EMPTY, RX_USEDW} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL pop_empty: empty=%b usedw=%0d, required 1/0", RX_EMPTY, RX_USEDW);
    end
  endtask

  task automatic test_back_to_back();
    logic emp;
    logic [7:0] d, exp_b;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (4) tick();
    n_cmp++;
    if (RX_USEDW !== 5'(exp_q.size())) begin
      n_err++; $display("FAIL b2b_usedw: usedw=%0d, required %0d", RX_USEDW, exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      exp_b = exp_q.pop_front();
      do_pop(emp, d);
      n_cmp++;
      if ({emp, d} !== {1'b0, exp_b}) begin
        n_err++; $display("FAIL b2b_pop%0d: empty=%b data=%h, required 0/%h", i, emp, d, exp_b);
      end
    end
  endtask

  task automatic test_frame_err();
    int ferr_cnt = 0;
    logic emp;
    logic [7:0] d, exp_b;
    fork
      send_byte(8'h55, 1'b0);
      for (int i = 0; i < 10 * DIV + 4; i++) begin
        tick();
        if (FRAME_ERR === 1'b1) ferr_cnt++;
      end
    join
    n_cmp++;
    if (ferr_cnt !== 1) begin n_err++; $display("FAIL ferr_pulse: cycles=%0d, required 1", ferr_cnt); end
    n_cmp++;
    if (RX_USEDW !== 5'd0) begin n_err++; $display("FAIL ferr_usedw: usedw=%0d, required 0", RX_USEDW); end
    send_byte(8'h12, 1'b1);
    exp_b = exp_q.pop_front();
    do_pop(emp, d);
    n_cmp++;
    if ({emp, d} !== {1'b0, exp_b}) begin
      n_err++; $display("FAIL ferr_next: empty=%b data=%h, required 0/%h", emp, d, exp_b);
    end
  endtask

  task automatic test_glitch();
    int ferr_cnt = 0;
    logic emp;
    logic [7:0] d, exp_b;
    RXD = 1'b0;
    repeat (3) tick();
    RXD = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) begin
      tick();
      if (FRAME_ERR === 1'b1) ferr_cnt++;
    end
    n_cmp++;
    if ({RX_USEDW, 32'(ferr_cnt)} !== {5'd0, 32'd0}) begin
      n_err++; $display("FAIL glitch: usedw=%0d ferr=%0d, required 0/0", RX_USEDW, ferr_cnt);
    end
    send_byte(8'h6B, 1'b1);
    exp_b = exp_q.pop_front();
    do_pop(emp, d);
    n_cmp++;
    if ({emp, d} !== {1'b0, exp_b}) begin
      n_err++; $display("FAIL glitch_next: empty=%b data=%h, required 0/%h", emp, d, exp_b);
    end
    // line held low across reset release
    RXD = 1'b0;
    nRST = 1'b0;
    repeat (2) tick();
    nRST = 1'b1;
    repeat (15 * DIV) tick();
    n_cmp++;
    if ({RX_EMPTY, RX_USEDW} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL low_reset: empty=%b usedw=%0d, required 1/0", RX_EMPTY, RX_USEDW);
    end
    RXD = 1'b1;
    repeat (DIV) tick();
    send_byte(8'h5A, 1'b1);
    exp_b = exp_q.pop_front();
    do_pop(emp, d);
    n_cmp++;
    if ({emp, d} !== {1'b0, exp_b}) begin
      n_err++; $display("FAIL low_reset_next: empty=%b data=%h, required 0/%h", emp, d, exp_b);
    end
  endtask

  task automatic test_overrun();
    logic emp, head_emp;
    logic [7:0] d, exp_b, head_d, head_exp;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    n_cmp++;
    if (RX_USEDW !== 5'd16) begin n_err++; $display("FAIL full_usedw: usedw=%0d, required 16", RX_USEDW); end
    fork
      send_byte(8'h10, 1'b1);
      begin
        repeat (116) tick();
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
      end
    join
    n_cmp++;
    if ({OVERRUN, RX_USEDW} !== {exp_ovr, 5'(exp_q.size())}) begin
      n_err++; $display("FAIL overrun_set: ovr=%b usedw=%0d, required %b/%0d", OVERRUN, RX_USEDW, exp_ovr, exp_q.size());
    end
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    exp_ovr = 1'b0;
    n_cmp++;
    if (OVERRUN !== exp_ovr) begin n_err++; $display("FAIL overrun_clr: ovr=%b, required 0", OVERRUN); end
    fork
      send_byte(8'h20, 1'b1);
      begin
        repeat (116) tick();
        head_exp = exp_q.pop_front();
        head_emp = RX_EMPTY;
        head_d   = RX_DATA;
        RX_RD_REQ = 1'b1;
        tick();
        RX_RD_REQ = 1'b0;
      end
    join
    n_cmp++;
    if ({head_emp, head_d} !== {1'b0, head_exp}) begin
      n_err++; $display("FAIL full_pushpop_head: empty=%b data=%h, required 0/%h", head_emp, head_d, head_exp);
    end
    n_cmp++;
    if ({RX_USEDW, OVERRUN} !== {5'd16, exp_ovr}) begin
      n_err++; $display("FAIL full_pushpop: usedw=%0d ovr=%b, required 16/0", RX_USEDW, OVERRUN);
    end
    for (int i = 0; i < 16; i++) begin
      exp_b = exp_q.pop_front();
      do_pop(emp, d);
      n_cmp++;
      if ({emp, d} !== {1'b0, exp_b}) begin
        n_err++; $display("FAIL drain%0d: empty=%b data=%h, required 0/%h", i, emp, d, exp_b);
      end
    end
    n_cmp++;
    if ({RX_EMPTY, RX_USEDW} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL drained: empty=%b usedw=%0d, required 1/0", RX_EMPTY, RX_USEDW);
    end
  endtask

  task automatic test_reset_mid();
    logic emp;
    logic [7:0] d, exp_b, part;
    part = 8'h7E;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    n_cmp++;
    if (RX_USEDW !== 5'd2) begin n_err++; $display("FAIL pre_reset_usedw: usedw=%0d, required 2", RX_USEDW); end
    RXD = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 3; i++) begin
      RXD = part[i];
      repeat (DIV) tick();
    end
    RXD = part[3];
    repeat (DIV / 2) tick();
    nRST = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({RX_EMPTY, RX_USEDW} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL reset_mid: empty=%b usedw=%0d, required 1/0", RX_EMPTY, RX_USEDW);
    end
    RXD = 1'b1;
    repeat (2) tick();
    nRST = 1'b1;
    repeat (12 * DIV) tick();
    n_cmp++;
    if (RX_USEDW !== 5'd0) begin n_err++; $display("FAIL reset_mid_idle: usedw=%0d, required 0", RX_USEDW); end
    send_byte(8'h81, 1'b1);
    exp_b = exp_q.pop_front();
    do_pop(emp, d);
    n_cmp++;
    if ({emp, d} !== {1'b0, exp_b}) begin
      n_err++; $display("FAIL reset_mid_next: empty=%b data=%h, required 0/%h", emp, d, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
